baud_gen_prog: RTL and testbench

Runtime-programmable, fractional baud-rate generator. It is the next generation of the fixed-count baudrategen.
- Produces a 1-cycle oversample strobe (tick) for UART RX/TX sampling.
- Produces a per-bit strobe (bit_tick) every OVERSAMPLE ticks.
- Divisor (integer + fractional) is loadable at run time through a shadow register, with glitch-free switchover.
- A sync input lets the RX start-bit detector realign phase.

---
 rtl/baud_pkg.sv | 24 ++
 rtl/baud_gen_prog.sv | 154 +++++++++++++++
 tb/tb_baud_gen_prog.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared baud-rate settings and the divisor type used by the UART RX/TX
// and the configuration registers.
package baud_pkg;

  localparam int unsigned SYS_CLK_HZ   = 50_000_000;
  localparam int unsigned DIV_INT_W    = 16;
  localparam int unsigned DIV_FRAC_W   = 4;
  localparam int unsigned DEFAULT_DIV  = 163;
  localparam int unsigned DEFAULT_FRAC = 0;
  localparam int unsigned OVERSAMPLE   = 16;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
  } baud_div_t;

  function automatic baud_div_t baud_div_default();
    baud_div_t d;
    d.div_int  = DIV_INT_W'(DEFAULT_DIV);
    d.div_frac = DIV_FRAC_W'(DEFAULT_FRAC);
    return d;
  endfunction

endpackage

// File: rtl/baud_gen_prog.sv
// Fractional, runtime-programmable baud generator: oversample tick, bit tick,
// shadowed divisor with switchover on period boundaries, and phase resync.
module baud_gen_prog #(
  parameter int unsigned N_BITS       = baud_pkg::DIV_INT_W,
  parameter int unsigned N_FRAC       = baud_pkg::DIV_FRAC_W,
  parameter int unsigned OVERSAMPLE   = baud_pkg::OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV  = baud_pkg::DEFAULT_DIV,
  parameter int unsigned DEFAULT_FRAC = baud_pkg::DEFAULT_FRAC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic [N_BITS-1:0] div_int,
  input  logic [N_FRAC-1:0] div_frac,
  input  logic              div_load,
  output logic              tick,
  output logic              bit_tick,
  output logic              div_pending
);

  localparam int unsigned       OS_W     = $clog2(OVERSAMPLE);
  localparam logic [N_BITS-1:0] DEF_INT  = (DEFAULT_DIV == 0) ? N_BITS'(1) : N_BITS'(DEFAULT_DIV);
  localparam logic [N_FRAC-1:0] DEF_FRAC = N_FRAC'(DEFAULT_FRAC);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);

  // cnt is one bit wider so that last = max_int - 1 + carry still fits
  logic [N_BITS:0]   cnt_q, cnt_d;
  logic [N_FRAC-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [N_BITS-1:0] act_int_q, act_int_d;
  logic [N_FRAC-1:0] act_frac_q, act_frac_d;
  logic [N_BITS-1:0] shd_int_q, shd_int_d;
  logic [N_FRAC-1:0] shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;
  logic              bit_q, bit_d;

  logic [N_BITS-1:0] ld_int_s;
  logic [N_BITS:0]   last_s;
  logic [N_FRAC:0]   sum_s;
  logic              term_s;

  // Terminal-count and fractional-carry arithmetic
  always_comb begin
    ld_int_s = (div_int == '0) ? N_BITS'(1) : div_int;
    last_s   = {1'b0, act_int_q} + {{N_BITS{1'b0}}, ext_q} - (N_BITS + 1)'(1);
    sum_s    = {1'b0, acc_q} + {1'b0, act_frac_q};
    term_s   = (cnt_q == last_s);
  end

  // Next-state: sync > apply/terminal > count
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    os_d       = os_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    bit_d      = 1'b0;

    if (div_load) begin
      shd_int_d  = ld_int_s;
      shd_frac_d = div_frac;
      pend_d     = 1'b1;
    end else begin
      shd_int_d  = shd_int_q;
      shd_frac_d = shd_frac_q;
    end

    if (sync) begin
      cnt_d = '0;
      acc_d = '0;
      ext_d = 1'b0;
      os_d  = '0;
      if (div_load || pend_q) begin
        act_int_d  = shd_int_d;
        act_frac_d = shd_frac_d;
        pend_d     = 1'b0;
      end else begin
        pend_d = pend_q;
      end
    end else if (!enable) begin
      // Idle apply takes the shadow as it stood; a same-cycle load stays pending
      if (pend_q) begin
        cnt_d      = '0;
        acc_d      = '0;
        ext_d      = 1'b0;
        os_d       = '0;
        act_int_d  = shd_int_q;
        act_frac_d = shd_frac_q;
        pend_d     = div_load;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (term_s) begin
      tick_d = 1'b1;
      bit_d  = (os_q == OS_LAST);
      if (div_load || pend_q) begin
        cnt_d      = '0;
        acc_d      = '0;
        ext_d      = 1'b0;
        os_d       = '0;
        act_int_d  = shd_int_d;
        act_frac_d = shd_frac_d;
        pend_d     = 1'b0;
      end else begin
        cnt_d = '0;
        acc_d = sum_s[N_FRAC-1:0];
        ext_d = sum_s[N_FRAC];
        os_d  = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
      end
    end else begin
      cnt_d = cnt_q + (N_BITS + 1)'(1);
    end
  end

  // State register with synchronous reset to the default divisor
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
      os_q       <= '0;
      act_int_q  <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      shd_int_q  <= DEF_INT;
      shd_frac_q <= DEF_FRAC;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      os_q       <= os_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
    end
  end

  assign tick        = tick_q;
  assign bit_tick    = bit_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Scoreboard bench for baud_gen_prog: expected tick edges are queued by the
// stimulus, a negedge monitor pops one per observed tick.
module tb_baud_gen_prog;

  logic        clock = 1'b0;
  logic        reset, enable, sync, div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        tick, bit_tick, div_pending;

  typedef struct {
    int unsigned at;
    logic        bt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned frac_offs[8] = '{9, 19, 30, 40, 51, 61, 72, 82};

  baud_gen_prog #(
    .N_BITS(16), .N_FRAC(4), .OVERSAMPLE(16), .DEFAULT_DIV(163), .DEFAULT_FRAC(0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sync(sync),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .tick(tick), .bit_tick(bit_tick), .div_pending(div_pending)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned at, input logic bt);
    exp_t e;
    e.at = at;
    e.bt = bt;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int unsigned e);
    while (cyc < e) @(negedge clock);
  endtask

  task automatic do_reset(input logic en, output int unsigned e0);
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; sync = 1'b0; div_load = 1'b0;
    @(negedge clock);
    reset = 1'b0; enable = en;
    e0 = cyc + 1;
  endtask

  task automatic end_scn(input string nm, input int unsigned last);
    wait_until(last);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check({nm, "_missing_ticks"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every observed strobe must match the oldest queued expectation
  always @(negedge clock) begin : mon
    exp_t e;
    if (tick === 1'b1 || bit_tick === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: got tick at edge %0d bit_tick %0b, expected none", cyc, bit_tick);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc || e.bt !== bit_tick || tick !== 1'b1) begin
          n_err++;
          $display("FAIL tick_time: got edge %0d tick %0b bit_tick %0b, expected edge %0d tick 1 bit_tick %0b",
                   cyc, tick, bit_tick, e.at, e.bt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at edge %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    reset = 1'b1; enable = 1'b0; sync = 1'b0; div_load = 1'b0;
    div_int = 16'd0; div_frac = 4'd0;
    repeat (3) @(negedge clock);
    check("rst_tick", tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_pending", div_pending, 0);

    // Defaults: tick every 163, bit_tick on the 16th
    do_reset(1'b1, e0);
    for (int k = 1; k <= 16; k++) push(e0 + 163 * k - 1, (k == 16));
    end_scn("dflt", e0 + 163 * 16 - 1);

    // 10 + 8/16 loaded while idle: periods 10,10,11,10,11,...
    do_reset(1'b0, e0);
    div_int = 16'd10; div_frac = 4'd8; div_load = 1'b1;
    @(negedge clock);
    div_load = 1'b0;
    check("pend_set_idle", div_pending, 1);
    @(negedge clock);
    check("pend_apply_idle", div_pending, 0);
    enable = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 8; k++) push(e0 + frac_offs[k], 1'b0);
    end_scn("frac", e0 + frac_offs[7]);

    // Load 20 mid-period while running at 163
    do_reset(1'b1, e0);
    push(e0 + 162, 1'b0);
    push(e0 + 325, 1'b0);
    for (int k = 1; k <= 16; k++) push(e0 + 325 + 20 * k, (k == 16));
    wait_until(e0 + 212);
    div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clock);
    div_load = 1'b0;
    check("pend_set_run", div_pending, 1);
    wait_until(e0 + 324);
    check("pend_hold_run", div_pending, 1);
    @(negedge clock);
    check("pend_apply_term", div_pending, 0);
    end_scn("switch", e0 + 645);

    // Enable low for 37 cycles mid-period delays the tick by 37
    do_reset(1'b1, e0);
    push(e0 + 162, 1'b0);
    push(e0 + 362, 1'b0);
    wait_until(e0 + 212);
    enable = 1'b0;
    wait_until(e0 + 249);
    enable = 1'b1;
    end_scn("pause", e0 + 362);

    // Sync at cycle 80 of the second period restarts phase and os count
    do_reset(1'b1, e0);
    push(e0 + 162, 1'b0);
    for (int k = 1; k <= 16; k++) push(e0 + 243 + 163 * k, (k == 16));
    wait_until(e0 + 242);
    sync = 1'b1;
    @(negedge clock);
    sync = 1'b0;
    end_scn("sync", e0 + 243 + 163 * 16);

    // Divisor 0 acts as 1: tick every cycle; then reset mid-stream
    do_reset(1'b0, e0);
    div_int = 16'd0; div_frac = 4'd0; div_load = 1'b1;
    @(negedge clock);
    div_load = 1'b0;
    @(negedge clock);
    check("pend_apply_div0", div_pending, 0);
    enable = 1'b1;
    e0 = cyc + 1;
    for (int k = 1; k <= 20; k++) push(e0 + k - 1, (k == 16));
    wait_until(e0 + 19);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_tick", tick, 0);
    check("rst_mid_bit_tick", bit_tick, 0);
    check("rst_mid_pending", div_pending, 0);
    check("div1_missing_ticks", exp_q.size(), 0);
    reset = 1'b0;
    enable = 1'b1;
    e0 = cyc + 1;
    push(e0 + 162, 1'b0);
    push(e0 + 325, 1'b0);
    end_scn("restore", e0 + 325);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
